move_sequencer: RTL

Game-turn controller for the Connect-4 datapath. It turns a button press and a one-hot column switch into one legal disc drop, and owns the board occupancy, owner and column-height state. It runs a request/done handshake with the winner detector, then alternates players or ends the game. It sits between the switch/button inputs and the win-detection and status-display blocks, and replaces ad-hoc per-column counting.

---
 rtl/move_sequencer_pkg.sv | 26 ++
 rtl/move_sequencer_btn_edge_sync.sv | 35 +++
 rtl/move_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_pkg.sv
// Purpose: shared encodings for the Connect-4 turn controller, winner detector and status display.
// Latency: n/a (types, constants and a pure index function only).
// Backpressure: n/a.
package move_sequencer_pkg;

    // Game status encodings, also decoded by the detector and display blocks.
    localparam logic [1:0] STATUS_PLAYING = 2'b00;
    localparam logic [1:0] STATUS_P1      = 2'b01;
    localparam logic [1:0] STATUS_P2      = 2'b10;
    localparam logic [1:0] STATUS_DRAW    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VALIDATE,
        ST_PLACE,
        ST_CHECK,
        ST_NEXT,
        ST_OVER
    } state_t;

    // Flat board index; row 0 is the bottom row.
    function automatic int cell_index(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/move_sequencer_btn_edge_sync.sv
// Purpose: 2-flop synchronizer for an asynchronous push-button plus a one-cycle rising-edge pulse.
// Latency: pulse appears 2 cycles after the button is first sampled high.
// Backpressure: none; the pulse is single-cycle and is not held.
// Ports: clk/reset (sync, active-high), btn (async raw input), rise (one-cycle pulse).
module move_sequencer_btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync1_q, sync2_q, prev_q;
    logic sync1_d, sync2_d, prev_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/move_sequencer.sv
// Purpose: Connect-4 turn controller; validates a column drop, updates the board, handshakes with the winner detector.
// Latency: btn edge to check_req is 5 cycles; minimum turn is 7 cycles with a same-cycle check_done.
// Backpressure: button edges outside IDLE are dropped, not queued; a silent detector times out after CHECK_TIMEOUT cycles.
// Ports: clk, reset (sync, active-high); btn, col_sel in; occupied/owner/player board state out;
//        check_req/last_cell out and check_done/check_win in to the detector; status/illegal/busy out.
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int COLS          = 4,
    parameter int ROWS          = 4,
    parameter int CHECK_TIMEOUT = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               btn,
    input  logic [COLS-1:0]                    col_sel,
    output logic [COLS*ROWS-1:0]               occupied,
    output logic [COLS*ROWS-1:0]               owner,
    output logic                               player,
    output logic                               check_req,
    output logic [$clog2(COLS*ROWS)-1:0]       last_cell,
    input  logic                               check_done,
    input  logic                               check_win,
    output logic [1:0]                         status,
    output logic                               illegal,
    output logic                               busy
);

    localparam int CELLS  = COLS * ROWS;
    localparam int CELL_W = $clog2(CELLS);
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int HGT_W  = $clog2(ROWS + 1);
    localparam int MOV_W  = $clog2(CELLS + 1);
    localparam int TMR_W  = $clog2(CHECK_TIMEOUT + 1);

    logic btn_rise;

    move_sequencer_btn_edge_sync u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .rise  (btn_rise)
    );

    state_t                        state_q,     state_d;
    logic [CELLS-1:0]              occupied_q,  occupied_d;
    logic [CELLS-1:0]              owner_q,     owner_d;
    logic                          player_q,    player_d;
    logic [1:0]                    status_q,    status_d;
    logic                          check_req_q, check_req_d;
    logic                          illegal_q,   illegal_d;
    logic                          busy_q,      busy_d;
    logic [CELL_W-1:0]             last_cell_q, last_cell_d;
    logic [COLS-1:0][HGT_W-1:0]    height_q,    height_d;
    logic [MOV_W-1:0]              moves_q,     moves_d;
    logic [COLS-1:0]               col_sel_q,   col_sel_d;
    logic [COL_W-1:0]              col_idx_q,   col_idx_d;
    logic [TMR_W-1:0]              timer_q,     timer_d;

    logic [COL_W-1:0]              sel_idx;
    logic [CELL_W-1:0]             place_idx;

    // Column number of the (registered) switch pattern; only meaningful when one-hot.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < COLS; i++) begin
            if (col_sel_q[i]) sel_idx = COL_W'(i);
        end
    end

    // Target cell sits on top of the column's current stack.
    assign place_idx = CELL_W'(cell_index(int'(height_q[col_idx_q]), int'(col_idx_q), COLS));

    always_comb begin
        state_d     = state_q;
        occupied_d  = occupied_q;
        owner_d     = owner_q;
        player_d    = player_q;
        status_d    = status_q;
        check_req_d = 1'b0;
        illegal_d   = 1'b0;
        last_cell_d = last_cell_q;
        height_d    = height_q;
        moves_d     = moves_q;
        col_sel_d   = col_sel_q;
        col_idx_d   = col_idx_q;
        timer_d     = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (btn_rise) begin
                    col_sel_d = col_sel;
                    state_d   = ST_VALIDATE;
                end
            end
            ST_VALIDATE: begin
                col_idx_d = sel_idx;
                if ($onehot(col_sel_q) && (height_q[sel_idx] < HGT_W'(ROWS))) begin
                    state_d = ST_PLACE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_PLACE: begin
                occupied_d[place_idx] = 1'b1;
                owner_d[place_idx]    = player_q;
                if (height_q[col_idx_q] < HGT_W'(ROWS)) begin
                    height_d[col_idx_q] = height_q[col_idx_q] + 1'b1;
                end
                moves_d     = moves_q + 1'b1;
                last_cell_d = place_idx;
                timer_d     = '0;
                check_req_d = 1'b1;
                state_d     = ST_CHECK;
            end
            ST_CHECK: begin
                if (check_done) begin
                    if (check_win) begin
                        status_d = player_q ? STATUS_P2 : STATUS_P1;
                        state_d  = ST_OVER;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else if (timer_q == TMR_W'(CHECK_TIMEOUT - 1)) begin
                    // Detector silent: treat the move as non-winning.
                    state_d = ST_NEXT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_NEXT: begin
                if (moves_q == MOV_W'(CELLS)) begin
                    status_d = STATUS_DRAW;
                    state_d  = ST_OVER;
                end else begin
                    player_d = ~player_q;
                    state_d  = ST_IDLE;
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            occupied_q  <= '0;
            owner_q     <= '0;
            player_q    <= 1'b0;
            status_q    <= STATUS_PLAYING;
            check_req_q <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            last_cell_q <= '0;
            height_q    <= '0;
            moves_q     <= '0;
            col_sel_q   <= '0;
            col_idx_q   <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            occupied_q  <= occupied_d;
            owner_q     <= owner_d;
            player_q    <= player_d;
            status_q    <= status_d;
            check_req_q <= check_req_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            last_cell_q <= last_cell_d;
            height_q    <= height_d;
            moves_q     <= moves_d;
            col_sel_q   <= col_sel_d;
            col_idx_q   <= col_idx_d;
            timer_q     <= timer_d;
        end
    end

    assign occupied  = occupied_q;
    assign owner     = owner_q;
    assign player    = player_q;
    assign status    = status_q;
    assign check_req = check_req_q;
    assign illegal   = illegal_q;
    assign busy      = busy_q;
    assign last_cell = last_cell_q;

endmodule
